// File: rtl/cls_pipe_addsub.sv
// Pipelined carry-lookahead add/sub, one 16-bit slice per stage; CLS_PIPE_SAT_EN enables signed saturation.
// Latency STAGES = WIDTH/16 cycles, one beat per cycle.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready.
module cls_pipe_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / 16;
    localparam int L      = STAGES - 1;

    // Per-stage registers (_q), their next values (_d) and each stage's inputs (_s)
    logic             vld_q [STAGES], vld_d [STAGES], vld_s [STAGES];
    logic             op_q  [STAGES], op_d  [STAGES], op_s  [STAGES];
    logic             cy_q  [STAGES], cy_d  [STAGES], cy_s  [STAGES];
    logic             zr_q  [STAGES], zr_d  [STAGES], zr_s  [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES], x_d   [STAGES], x_s   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES], y_d   [STAGES], y_s   [STAGES];
    logic [WIDTH-1:0] res_q [STAGES], res_d [STAGES], res_s [STAGES];
    logic             ovf_q, ovf_d, cout_q, cout_d;
    logic             adv;

    // 16-bit slice: four 4-bit lookahead groups joined by a group PG unit
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c0);
        logic [15:0] g, p, s;
        logic [3:0]  gg, pg;
        logic [4:0]  gc;
        logic        c;
        g = a & b;
        p = a ^ b;
        s = '0;
        c = 1'b0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        gc[0] = c0;
        for (int j = 0; j < 4; j++) gc[j+1] = gg[j] | (pg[j] & gc[j]);
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) c = gc[i/4];
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return {gc[4], s};
    endfunction

    assign adv       = ~vld_q[L] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[L];
    assign d         = res_q[L];
    assign zero      = zr_q[L];
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Subtraction runs as x + ~y + ~cin, so the internal carry is an inverted borrow
    always_comb begin
        vld_s[0] = in_valid;
        op_s[0]  = op_sub;
        cy_s[0]  = cin ^ op_sub;
        zr_s[0]  = 1'b1;
        x_s[0]   = x;
        y_s[0]   = y;
        res_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_s[k] = vld_q[k-1];
            op_s[k]  = op_q[k-1];
            cy_s[k]  = cy_q[k-1];
            zr_s[k]  = zr_q[k-1];
            x_s[k]   = x_q[k-1];
            y_s[k]   = y_q[k-1];
            res_s[k] = res_q[k-1];
        end
    end

    always_comb begin
        logic [16:0] sl;
        sl = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl       = cla16(x_s[k][16*k +: 16], y_s[k][16*k +: 16] ^ {16{op_s[k]}}, cy_s[k]);
            vld_d[k] = vld_s[k];
            op_d[k]  = op_s[k];
            x_d[k]   = x_s[k];
            y_d[k]   = y_s[k];
            res_d[k] = res_s[k];
            res_d[k][16*k +: 16] = sl[15:0];
            cy_d[k]  = sl[16];
            zr_d[k]  = zr_s[k] & ~|sl[15:0];
        end
        cout_d = cy_d[L] ^ op_s[L];
        ovf_d  = (op_s[L] ? (x_s[L][WIDTH-1] ^ y_s[L][WIDTH-1])
                          : ~(x_s[L][WIDTH-1] ^ y_s[L][WIDTH-1]))
               & (res_d[L][WIDTH-1] ^ x_s[L][WIDTH-1]);
`ifdef CLS_PIPE_SAT_EN
        // Overflow always lands on the side of x's sign; clamped values are never zero
        if (ovf_d) begin
            res_d[L] = x_s[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            zr_d[L]  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                op_q[k]  <= 1'b0;
                cy_q[k]  <= 1'b0;
                zr_q[k]  <= 1'b0;
                x_q[k]   <= '0;
                y_q[k]   <= '0;
                res_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                op_q[k]  <= op_d[k];
                cy_q[k]  <= cy_d[k];
                zr_q[k]  <= zr_d[k];
                x_q[k]   <= x_d[k];
                y_q[k]   <= y_d[k];
                res_q[k] <= res_d[k];
            end
            ovf_q  <= ovf_d;
            cout_q <= cout_d;
        end
    end
endmodule

// File: tb/tb_cls_pipe_addsub.sv
// Bench for cls_pipe_addsub (WIDTH=32): queue-based arithmetic model checked every cycle,
// directed corner beats, stall/reset scenarios and a 10k-beat random run.
module tb_cls_pipe_addsub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, cin = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] d;

    typedef struct {
        logic [31:0] d;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   adv_cnt = 0;
    int   n_acc   = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    cls_pipe_addsub #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .x(x), .y(y), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .d(d), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, flags from the mathematical result
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic op, input logic c);
        exp_t        e;
        logic [32:0] u;
        longint      r;
        if (!op) begin
            u      = {1'b0, a} + {1'b0, b} + 33'(c);
            r      = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
            e.cout = u[32];
        end else begin
            u      = {1'b0, a} - {1'b0, b} - 33'(c);
            r      = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
            e.cout = ({1'b0, a} < ({1'b0, b} + 33'(c)));
        end
        e.d   = u[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef CLS_PIPE_SAT_EN
        if (e.ovf) e.d = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.zero = (e.d == 32'h0);
        e.tag  = 0;
        return e;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Every cycle: compare outputs against the model, then advance the model for the coming edge
    always @(negedge clk) begin : cmp
        logic ev;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            check("rst_out_valid", out_valid, 0);
            check("rst_d", d, 0);
            check("rst_flags", {cout, ovf, zero}, 0);
        end else begin
            ev = (q.size() > 0) && (adv_cnt - q[0].tag == STAGES - 1);
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, !ev || out_ready);
            if (ev) begin
                check("d", d, q[0].d);
                check("cout", cout, q[0].cout);
                check("ovf", ovf, q[0].ovf);
                check("zero", zero, q[0].zero);
            end
            if (ev && out_ready) e = q.pop_front();
            if (!ev || out_ready) begin
                adv_cnt++;
                if (in_valid) begin
                    e     = model(x, y, op_sub, cin);
                    e.tag = adv_cnt;
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
    end

    // One beat from an idle pipe; result must appear exactly STAGES cycles later
    task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic c, input logic [31:0] exp_d);
        in_valid = 1'b1; x = a; y = b; op_sub = op; cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_early"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_d"}, d, exp_d);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t m;
        int   target;

        m = model(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
        check("m_add_d", m.d, 32'h0001_0000);
        check("m_add_flags", {m.cout, m.ovf, m.zero}, 3'b000);
        m = model(32'h0, 32'h1, 1'b1, 1'b0);
        check("m_sub_d", m.d, 32'hFFFF_FFFF);
        check("m_sub_flags", {m.cout, m.ovf, m.zero}, 3'b100);
        m = model(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1);
        check("m_subz_d", m.d, 32'h0);
        check("m_subz_zero", m.zero, 1);
        m = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        check("m_ovf", m.ovf, 1);
`ifdef CLS_PIPE_SAT_EN
        check("m_ovf_d", m.d, 32'h7FFF_FFFF);
`else
        check("m_ovf_d", m.d, 32'h8000_0000);
`endif
        m = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        check("m_wrap", {m.d, m.cout, m.zero}, {32'h0, 2'b11});

        // Reset held with in_valid high, then first beat after release
        in_valid = 1'b1; x = 32'd5; y = 32'd3; op_sub = 1'b0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("first_early", out_valid, 0);
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("first_d", d, 32'd8);
        @(posedge clk); #1;

        single("carry_x", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000);
        single("sub_neg", 32'h0, 32'h1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        single("sub_zero", 32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1, 32'h0);
`ifdef CLS_PIPE_SAT_EN
        single("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF);
`else
        single("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000);
`endif
        single("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0);

        // A, B, C back to back with the consumer stalled once A reaches the output
        out_ready = 1'b0;
        in_valid = 1'b1; x = 32'h1111_1111; y = 32'h2222_2222; op_sub = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        x = 32'h5000_0000; y = 32'h0000_0001; op_sub = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        x = 32'hABCD_0000; y = 32'h0000_1234; op_sub = 1'b0; cin = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_d", d, 32'h3333_3333);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abc_drained", q.size(), 0);

        // Reset with two beats in flight
        in_valid = 1'b1; x = 32'h0000_0010; y = 32'h0000_0020; op_sub = 1'b0;
        @(posedge clk); #1;
        x = 32'h0000_0030;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        target = n_acc + 10000;
        for (int c = 0; c < 40000 && n_acc < target; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = rval();
            y         = rval();
            op_sub    = 1'($urandom_range(0, 1));
            cin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        check("rand_beats", n_acc >= target, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(posedge clk); #1;
        end
        check("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
